// File: rtl/nand_bus_seq.sv
// Byte-level NAND flash bus sequencer: turns abstract CMD/ADDR/WDATA/RDATA/WAIT_RB
// operations into timed F_CLE/F_ALE/F_WEN/F_REN/F_IO pin activity and watches F_RB.
module nand_bus_seq #(
    parameter int T_WP       = 1,
    parameter int T_WH       = 1,
    parameter int T_RP       = 1,
    parameter int T_REH      = 1,
    parameter int T_WB       = 2,
    parameter int RB_TIMEOUT = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       op_valid,
    input  logic [2:0] op_type,
    input  logic [7:0] op_data,
    output logic       op_ready,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       rb_timeout,
    inout  wire  [7:0] F_IO,
    output logic       F_CLE,
    output logic       F_ALE,
    output logic       F_REN,
    output logic       F_WEN,
    input  logic       F_RB
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int T_MAX = max2(max2(max2(T_WP, T_WH), max2(T_RP, T_REH)), T_WB);
    localparam int CW    = $clog2(T_MAX + 1);
    localparam int TW    = $clog2(RB_TIMEOUT + 1);

    localparam logic [2:0] OP_CMD   = 3'd0;
    localparam logic [2:0] OP_ADDR  = 3'd1;
    localparam logic [2:0] OP_WDATA = 3'd2;
    localparam logic [2:0] OP_RDATA = 3'd3;
    localparam logic [2:0] OP_WAIT  = 3'd4;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WLOW  = 3'd1;
    localparam logic [2:0] S_WHIGH = 3'd2;
    localparam logic [2:0] S_RLOW  = 3'd3;
    localparam logic [2:0] S_RHIGH = 3'd4;
    localparam logic [2:0] S_WB    = 3'd5;
    localparam logic [2:0] S_RBW   = 3'd6;

    logic [2:0]    state;
    logic [2:0]    kind;
    logic [7:0]    byte_q;
    logic [CW-1:0] cnt;
    logic [TW-1:0] tcnt;
    logic          wr_phase;

    // NOTE: every register here is assigned with <= so all updates see pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            op_ready   <= 1'b0;
            kind       <= 3'd0;
            byte_q     <= 8'd0;
            cnt        <= '0;
            tcnt       <= '0;
            rd_data    <= 8'd0;
            rd_valid   <= 1'b0;
            rb_timeout <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    op_ready <= 1'b1;
                    if (op_valid && op_ready) begin
                        kind       <= op_type;
                        byte_q     <= op_data;
                        rb_timeout <= 1'b0;
                        op_ready   <= 1'b0;
                        case (op_type)
                            OP_CMD, OP_ADDR, OP_WDATA: begin
                                state <= S_WLOW;
                                cnt   <= CW'(T_WP - 1);
                            end
                            OP_RDATA: begin
                                state <= S_RLOW;
                                cnt   <= CW'(T_RP - 1);
                            end
                            OP_WAIT: begin
                                state <= S_WB;
                                cnt   <= CW'(T_WB - 1);
                            end
                            default: ; // reserved: one dead cycle, no pin activity
                        endcase
                    end
                end
                S_WLOW: begin
                    if (cnt == '0) begin
                        state <= S_WHIGH;
                        cnt   <= CW'(T_WH - 1);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_WHIGH: begin
                    if (cnt == '0) begin
                        state    <= S_IDLE;
                        op_ready <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_RLOW: begin
                    // Capture on the edge that ends the last REN-low cycle.
                    if (cnt == '0) begin
                        rd_data  <= F_IO;
                        rd_valid <= 1'b1;
                        state    <= S_RHIGH;
                        cnt      <= CW'(T_REH - 1);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_RHIGH: begin
                    if (cnt == '0) begin
                        state    <= S_IDLE;
                        op_ready <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_WB: begin
                    if (cnt == '0) begin
                        state <= S_RBW;
                        tcnt  <= TW'(RB_TIMEOUT - 1);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_RBW: begin
                    if (F_RB) begin
                        state    <= S_IDLE;
                        op_ready <= 1'b1;
                    end else if (tcnt == '0) begin
                        rb_timeout <= 1'b1;
                        state      <= S_IDLE;
                        op_ready   <= 1'b1;
                    end else begin
                        tcnt <= tcnt - 1'b1;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    op_ready <= 1'b0;
                end
            endcase
        end
    end

    // Pins decode straight from registered state, so reset idles them at the same edge.
    assign wr_phase = (state == S_WLOW) || (state == S_WHIGH);
    assign F_WEN    = (state != S_WLOW);
    assign F_REN    = (state != S_RLOW);
    assign F_CLE    = wr_phase && (kind == OP_CMD);
    assign F_ALE    = wr_phase && (kind == OP_ADDR);
    assign F_IO     = wr_phase ? byte_q : 8'hzz;

endmodule

// File: tb/tb_nand_bus_seq.sv
// Directed bench for nand_bus_seq: a flash-side model drives F_IO/F_RB and scoreboard
// queues hold the expected write-cycle pin values and read bytes.
module tb_nand_bus_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       op_valid_a = 1'b0;
    logic       op_valid_b = 1'b0;
    logic [2:0] op_type = 3'd0;
    logic [7:0] op_data = 8'd0;
    logic       rb = 1'b1;
    logic       flash_oe = 1'b0;
    logic [7:0] flash_byte = 8'd0;

    logic       op_ready, rd_valid, rb_timeout, F_CLE, F_ALE, F_REN, F_WEN;
    logic [7:0] rd_data;
    wire  [7:0] io_a;

    logic       op_ready_b, rd_valid_b, rb_timeout_b, cle_b, ale_b, ren_b, wen_b;
    logic [7:0] rd_data_b;
    wire  [7:0] io_b;

    assign io_a = flash_oe ? flash_byte : 8'hzz;

    always #5 clk = ~clk;

    nand_bus_seq #(.T_RP(2), .RB_TIMEOUT(32)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid_a), .op_type(op_type), .op_data(op_data),
        .op_ready(op_ready), .rd_data(rd_data), .rd_valid(rd_valid), .rb_timeout(rb_timeout),
        .F_IO(io_a), .F_CLE(F_CLE), .F_ALE(F_ALE), .F_REN(F_REN), .F_WEN(F_WEN), .F_RB(rb)
    );

    nand_bus_seq #(.RB_TIMEOUT(8)) dut_b (
        .clk(clk), .rst(rst), .op_valid(op_valid_b), .op_type(op_type), .op_data(op_data),
        .op_ready(op_ready_b), .rd_data(rd_data_b), .rd_valid(rd_valid_b), .rb_timeout(rb_timeout_b),
        .F_IO(io_b), .F_CLE(cle_b), .F_ALE(ale_b), .F_REN(ren_b), .F_WEN(wen_b), .F_RB(rb)
    );

    int tests = 0;
    int fails = 0;

    logic [9:0] wr_q[$];   // {cle, ale, byte}
    logic [7:0] rd_q[$];

    logic [7:0] addrs[3];
    int         acc_cyc[3];
    int         nxt, cyc, wen_pulses, ren_low, rv, early;
    logic       acc;
    logic [9:0] e;
    logic [7:0] r;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_wr(input string tag);
        if (wr_q.size() == 0) begin
            check({tag, "_queue_empty"}, 32'd1, 32'd0);
        end else begin
            e = wr_q.pop_front();
            check({tag, "_cle"}, 32'(F_CLE), 32'(e[9]));
            check({tag, "_ale"}, 32'(F_ALE), 32'(e[8]));
            check({tag, "_io"}, 32'(io_a), 32'(e[7:0]));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset held 4 cycles with a request pending; flash drives a marker to prove release.
        op_valid_a = 1'b1;
        flash_oe   = 1'b1;
        flash_byte = 8'h3C;
        repeat (4) tick();
        check("rst_op_ready", 32'(op_ready), 32'd0);
        check("rst_wen", 32'(F_WEN), 32'd1);
        check("rst_ren", 32'(F_REN), 32'd1);
        check("rst_cle", 32'(F_CLE), 32'd0);
        check("rst_ale", 32'(F_ALE), 32'd0);
        check("rst_io_released", 32'(io_a), 32'h3C);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rb_timeout", 32'(rb_timeout), 32'd0);
        op_valid_a = 1'b0;
        rst = 1'b1;
        tick();
        check("rst_release_ready", 32'(op_ready), 32'd1);
        flash_oe = 1'b0;

        // CMD 0x80
        wr_q.push_back({1'b1, 1'b0, 8'h80});
        op_type = 3'd0; op_data = 8'h80; op_valid_a = 1'b1;
        tick();
        op_valid_a = 1'b0;
        check("cmd_wen_low", 32'(F_WEN), 32'd0);
        pop_wr("cmd");
        check("cmd_ready_low", 32'(op_ready), 32'd0);
        tick();
        check("cmd_whigh_wen", 32'(F_WEN), 32'd1);
        check("cmd_whigh_cle", 32'(F_CLE), 32'd1);
        check("cmd_whigh_io_hold", 32'(io_a), 32'h80);
        tick();
        check("cmd_done_ready", 32'(op_ready), 32'd1);
        check("cmd_done_cle", 32'(F_CLE), 32'd0);

        // ADDR x3 back-to-back with op_valid held
        addrs[0] = 8'h12; addrs[1] = 8'h34; addrs[2] = 8'h56;
        for (int i = 0; i < 3; i++) begin
            wr_q.push_back({1'b0, 1'b1, addrs[i]});
            acc_cyc[i] = 0;
        end
        nxt = 0; cyc = 0; wen_pulses = 0;
        op_type = 3'd1; op_data = addrs[0]; op_valid_a = 1'b1;
        for (int i = 0; i < 15; i++) begin
            acc = op_valid_a && op_ready;
            tick();
            cyc++;
            if (acc) begin
                acc_cyc[nxt] = cyc;
                nxt++;
                if (nxt < 3) op_data = addrs[nxt];
                else op_valid_a = 1'b0;
            end
            if (!F_WEN) begin
                wen_pulses++;
                pop_wr("addr");
            end
        end
        op_valid_a = 1'b0;
        check("addr_accepts", 32'(nxt), 32'd3);
        check("addr_wen_pulses", 32'(wen_pulses), 32'd3);
        check("addr_spacing_1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
        check("addr_spacing_2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd3);

        // RDATA with T_RP=2 while the flash drives 0xA5
        flash_oe = 1'b1; flash_byte = 8'hA5;
        rd_q.push_back(8'hA5);
        op_type = 3'd3; op_valid_a = 1'b1;
        tick();
        op_valid_a = 1'b0;
        ren_low = 0; rv = 0;
        for (int i = 0; i < 6; i++) begin
            if (!F_REN) ren_low++;
            check("rd_wen_ren_excl", 32'(F_WEN | F_REN), 32'd1);
            check("rd_io_not_driven", 32'(io_a), 32'hA5);
            if (rd_valid) begin
                rv++;
                if (rd_q.size() == 0) begin
                    check("rd_queue_empty", 32'd1, 32'd0);
                end else begin
                    r = rd_q.pop_front();
                    check("rd_data", 32'(rd_data), 32'(r));
                end
            end
            tick();
        end
        check("rd_ren_low_cycles", 32'(ren_low), 32'd2);
        check("rd_valid_pulses", 32'(rv), 32'd1);
        check("rd_data_held", 32'(rd_data), 32'hA5);
        check("rd_done_ready", 32'(op_ready), 32'd1);
        flash_oe = 1'b0;

        // WAIT_RB, F_RB low for 10 cycles after accept
        rb = 1'b0;
        op_type = 3'd4; op_valid_a = 1'b1;
        tick();
        op_valid_a = 1'b0;
        early = 0;
        for (int i = 0; i < 10; i++) begin
            if (op_ready) early++;
            tick();
        end
        check("wrb_no_early_done", 32'(early), 32'd0);
        check("wrb_busy_before_rise", 32'(op_ready), 32'd0);
        rb = 1'b1;
        tick();
        check("wrb_done_after_rise", 32'(op_ready), 32'd1);
        check("wrb_no_timeout", 32'(rb_timeout), 32'd0);

        // WAIT_RB with F_RB already high: WB window ignored, then one RBW cycle
        op_valid_a = 1'b1;
        tick();
        op_valid_a = 1'b0;
        check("wrb_fast_wb1", 32'(op_ready), 32'd0);
        tick();
        check("wrb_fast_wb2", 32'(op_ready), 32'd0);
        tick();
        check("wrb_fast_rbw", 32'(op_ready), 32'd0);
        tick();
        check("wrb_fast_done", 32'(op_ready), 32'd1);

        // WAIT_RB timeout on the RB_TIMEOUT=8 instance
        rb = 1'b0;
        op_type = 3'd4; op_valid_b = 1'b1;
        tick();
        op_valid_b = 1'b0;
        repeat (9) tick();
        check("tmo_not_yet_ready", 32'(op_ready_b), 32'd0);
        check("tmo_not_yet_flag", 32'(rb_timeout_b), 32'd0);
        tick();
        check("tmo_ready", 32'(op_ready_b), 32'd1);
        check("tmo_flag", 32'(rb_timeout_b), 32'd1);
        op_type = 3'd0; op_data = 8'hC3; op_valid_b = 1'b1;
        tick();
        op_valid_b = 1'b0;
        check("tmo_cleared_on_accept", 32'(rb_timeout_b), 32'd0);
        check("tmo_next_cmd_wen", 32'(wen_b), 32'd0);
        repeat (2) tick();
        rb = 1'b1;

        // Reserved op_type: one dead cycle, pins idle
        op_type = 3'd5; op_valid_a = 1'b1;
        tick();
        op_valid_a = 1'b0;
        check("rsv_ready_drop", 32'(op_ready), 32'd0);
        check("rsv_wen", 32'(F_WEN), 32'd1);
        check("rsv_ren", 32'(F_REN), 32'd1);
        tick();
        check("rsv_ready_back", 32'(op_ready), 32'd1);

        // Reset in the middle of WLOW
        op_type = 3'd0; op_data = 8'h70; op_valid_a = 1'b1;
        tick();
        op_valid_a = 1'b0;
        check("mid_rst_wlow", 32'(F_WEN), 32'd0);
        rst = 1'b0;
        tick();
        check("mid_rst_wen", 32'(F_WEN), 32'd1);
        check("mid_rst_cle", 32'(F_CLE), 32'd0);
        check("mid_rst_ready", 32'(op_ready), 32'd0);
        rst = 1'b1;
        tick();
        check("mid_rst_release", 32'(op_ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
